// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the multi-channel PWM
package pwm_pkg;

    typedef enum logic {
        PwmEdge   = 1'b0,
        PwmCentre = 1'b1
    } pwm_mode_e;

    // Reset period is the largest value the counter width can hold.
    function automatic logic [63:0] default_period(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared period counter, direction, boundary detect and period/mode shadowing
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CtrSize = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               period_we,
    input  logic [CtrSize-1:0] period_wdata,
    input  logic               mode_we,
    input  pwm_mode_e          mode_wdata,
    output logic [CtrSize-1:0] counter,
    output logic               boundary,
    output logic               period_start,
    output logic               pending_diff
);

    localparam logic [CtrSize-1:0] PeriodRst = CtrSize'(default_period(CtrSize));
    localparam logic [CtrSize-1:0] One       = CtrSize'(1);

    logic [CtrSize-1:0] period_pend;
    logic [CtrSize-1:0] period_act;
    logic [CtrSize-1:0] period_next;
    pwm_mode_e          mode_pend;
    pwm_mode_e          mode_act;
    pwm_mode_e          mode_next;
    logic               dir_down;

    // A write landing in the boundary cycle is forwarded straight into the active copy.
    always_comb begin
        period_next = period_we ? period_wdata : period_pend;
        mode_next   = mode_we ? mode_wdata : mode_pend;
    end

    always_comb begin
        boundary = 1'b0;
        if (mode_act == PwmEdge) begin
            boundary = (counter == period_act);
        end else begin
            boundary = (dir_down && counter == One) ||
                       (!dir_down && counter == period_act && period_act <= One);
        end
    end

    assign pending_diff = (period_pend != period_act) || (mode_pend != mode_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            counter      <= '0;
            dir_down     <= 1'b0;
            period_pend  <= PeriodRst;
            period_act   <= PeriodRst;
            mode_pend    <= PwmEdge;
            mode_act     <= PwmEdge;
            period_start <= 1'b0;
        end else begin
            period_pend  <= period_next;
            mode_pend    <= mode_next;
            // Lines up with the pwm output register, which also lags the counter by one.
            period_start <= (counter == '0);
            if (boundary) begin
                counter    <= '0;
                dir_down   <= 1'b0;
                period_act <= period_next;
                mode_act   <= mode_next;
            end else if (mode_act == PwmCentre && !dir_down && counter == period_act) begin
                counter  <= counter - One;
                dir_down <= 1'b1;
            end else if (dir_down) begin
                counter <= counter - One;
            end else begin
                counter <= counter + One;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shadowed duty/period/mode and edge or centre alignment
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                     NumChannels = 4,
    parameter int                     CtrSize     = 8,
    parameter logic [NumChannels-1:0] OutInvert   = '0,
    localparam int                    ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
    input  logic                   clk_sys_i,
    input  logic                   rst_sys_i,
    input  logic                   duty_we_i,
    input  logic [ChanW-1:0]       duty_chan_i,
    input  logic [CtrSize-1:0]     duty_i,
    input  logic                   period_we_i,
    input  logic [CtrSize-1:0]     period_i,
    input  logic                   mode_we_i,
    input  logic                   mode_i,
    input  logic [NumChannels-1:0] enable_i,
    output logic [NumChannels-1:0] pwm_o,
    output logic                   period_start_o,
    output logic                   update_pending_o
);

    logic [CtrSize-1:0]     counter;
    logic                   boundary;
    logic                   timebase_diff;
    logic [NumChannels-1:0] duty_diff;
    logic [NumChannels-1:0] pwm_raw;

    pwm_timebase #(
        .CtrSize(CtrSize)
    ) u_timebase (
        .clk          (clk_sys_i),
        .rst          (rst_sys_i),
        .period_we    (period_we_i),
        .period_wdata (period_i),
        .mode_we      (mode_we_i),
        .mode_wdata   (pwm_mode_e'(mode_i)),
        .counter      (counter),
        .boundary     (boundary),
        .period_start (period_start_o),
        .pending_diff (timebase_diff)
    );

    // Out-of-range channel indices match no channel, so such writes fall away.
    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        logic [CtrSize-1:0] duty_pend;
        logic [CtrSize-1:0] duty_act;
        logic [CtrSize-1:0] duty_next;

        always_comb begin
            duty_next = (duty_we_i && duty_chan_i == ChanW'(c)) ? duty_i : duty_pend;
        end

        always_ff @(posedge clk_sys_i) begin
            if (rst_sys_i) begin
                duty_pend <= '0;
                duty_act  <= '0;
            end else begin
                duty_pend <= duty_next;
                if (boundary) begin
                    duty_act <= duty_next;
                end
            end
        end

        assign duty_diff[c] = (duty_pend != duty_act);
        assign pwm_raw[c]   = enable_i[c] && (counter < duty_act);
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            pwm_o <= OutInvert;
        end else begin
            pwm_o <= pwm_raw ^ OutInvert;
        end
    end

    assign update_pending_o = timebase_diff || (|duty_diff);

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator: one shared period counter drives NumChannels compare outputs.
- Per-channel duty and the common period are programmable.
- Double-buffered shadow registers give glitch-free updates at period boundaries.
- Edge-aligned or centre-aligned counting is selectable.
- Sits between the register interface (GPIO/LED/motor control) and pads; supersedes the single-compare, fixed-period PWM.

Parameters:
NumChannels, 4, number of PWM output channels (1..32)
CtrSize, 8, width of counter, period and duty values
OutInvert, '0 (NumChannels bits), per-channel output polarity; bit=1 inverts that channel's output and idle level

Ports:
clk_sys_i  input  1  system clock
rst_sys_i  input  1  synchronous reset, active-high
duty_we_i  input  1  write strobe for pending duty
duty_chan_i  input  $clog2(NumChannels) (min 1)  channel index for duty write
duty_i  input  CtrSize  duty value to write
period_we_i  input  1  write strobe for pending period
period_i  input  CtrSize  period value P (period length P+1 edge / 2P centre)
mode_we_i  input  1  write strobe for pending mode
mode_i  input  1  0=edge-aligned, 1=centre-aligned
enable_i  input  NumChannels  per-channel enable, not shadowed
pwm_o  output  NumChannels  modulated outputs, registered
period_start_o  output  1  one-cycle pulse in the first cycle of each period
update_pending_o  output  1  high while any pending value differs from its active value

Behaviour:
- Reset values:
  - counter=0, direction=up
  - pending/active duty = 0
  - pending/active period = 2**CtrSize-1, mode = edge
  - pwm_o = OutInvert (idle level); period_start_o = 0; update_pending_o = 0
- Writes update pending registers only.
  - Duty write with duty_chan_i >= NumChannels is ignored.
  - Simultaneous writes to different fields all take effect.
- Boundary cycle B (the last cycle of a period):
  - edge: counter == P_act
  - centre: (dir==down && counter==1) || (dir==up && counter==P_act && P_act<=1)
- Cycle after B:
  - counter = 0, dir = up
  - active <= pending for all fields
  - a write in cycle B is included (bypass), so it is active next period
- Edge mode: counter 0,1..P_act then wrap; period = P_act+1 cycles.
- Centre mode: up 0..P_act, then down P_act-1..1; period = 2*P_act cycles (1 cycle if P_act=0).
  - Direction flips to down in the cycle counter == P_act (P_act >= 2).
- P_act=0 (either mode): counter stays 0; every cycle is a boundary.
- Compare: raw[c] = enable_i[c] && (counter < duty_act[c]).
  - Registered: pwm_o[c] <= raw[c] ^ OutInvert[c]; latency 1 cycle from counter value to pin.
  - duty_act = 0 gives constant idle level.
  - duty_act > P_act gives 100% high (edge and centre).
  - Edge duty D (0 <= D <= P_act+1) gives exactly D high cycles per period.
  - Centre duty D gives 2D-1 high cycles for 1 <= D <= P_act, symmetric around counter==0.
- enable_i deassert: pwm_o goes to idle level on the next edge, no boundary wait. Re-enable resumes mid-period.
- period_start_o: registered, high in the same cycle as the pwm_o reflecting counter==0.
- update_pending_o: combinational compare of pending vs active; clears the cycle after B.
- Reset mid-period: all state returns to reset values next edge; no partial pulse is retained.
- Counter arithmetic is CtrSize wide; it never exceeds P_act, so it never overflows.

Decomposition:
- pwm_pkg holds:
  - typedef pwm_mode_e {PwmEdge=1'b0, PwmCentre=1'b1}
  - the default-period constant function
- One sub-module, pwm_timebase: counter, direction, boundary detect, active period/mode shadowing, period_start generation.
- Per-channel duty shadow registers and compare stay in pwm_multi via a generate loop.

Test Plan:
- Reset, then enable all; default P=255, duty 0 -> every pwm_o stays at OutInvert; period_start_o pulses every 256 cycles.
- Edge, P=9, duty ch0=3, ch1=0, ch2=10, ch3=5 -> high-cycle counts per 10-cycle period are 3/0/10/5; ch0 high at counter 0..2, seen on pwm_o one cycle later.
- Write ch0 duty 3->7 mid-period (counter=4) -> current period keeps 3 high cycles; next period shows 7; update_pending_o high from the write until the cycle after B.
- Write duty exactly in boundary cycle B (counter==P) -> new value applies in the immediately following period.
- Centre, P=4, duty 2 -> counter sequence 0,1,2,3,4,3,2,1 repeating (8 cycles); pwm_o high 3 cycles (counter 1,0,1 around wrap); period_start_o once per 8 cycles.
- OutInvert=4'b0010, ch1 duty 2, P=3, then enable_i[1] low mid-pulse and reset asserted mid-period -> ch1 inverted waveform (low 2, high 2); ch1 idle high next cycle after disable; after reset, counter=0 and pwm_o=4'b0010.
